// File: rtl/key_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : key_matrix_scanner
// Description : Row-by-row key matrix scanner with per-key debounce and a
//               press/release event FIFO (valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
module key_matrix_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SETTLE     = 1000,
  parameter int STABLE     = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int KW        = $clog2(ROWS * COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scan_en,
  output logic [ROWS-1:0]      row_n,
  input  logic [COLS-1:0]      col_n,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [KW-1:0]        evt_code,
  output logic                 evt_press,
  output logic                 evt_drop
);

  localparam int NKEYS = ROWS * COLS;
  localparam int RW    = $clog2(ROWS);
  localparam int CB    = $clog2(COLS);
  localparam int SW    = $clog2(SETTLE);
  localparam int DW    = $clog2(STABLE);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_drive  = 2'd1;
  localparam logic [1:0] c_sample = 2'd2;
  localparam logic [1:0] c_emit   = 2'd3;

  logic [COLS-1:0]  r_col_meta;
  logic [COLS-1:0]  r_col_sync;
  logic [1:0]       r_state;
  logic [RW-1:0]    r_row;
  logic [SW-1:0]    r_settle;
  logic [CB-1:0]    r_col;
  logic [COLS-1:0]  r_flip;
  logic [NKEYS-1:0] r_key_state;
  logic [DW-1:0]    r_cnt [NKEYS];

  logic [NKEYS-1:0] w_key_next;
  logic [DW-1:0]    w_cnt_next [NKEYS];
  logic [COLS-1:0]  w_flip_set;
  logic [KW-1:0]    w_emit_key;

  logic [KW:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_push_ok;

  // Columns idle high (pulled up), so the synchronizer resets to all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_meta <= '1;
      r_col_sync <= '1;
    end else begin
      r_col_meta <= col_n;
      r_col_sync <= r_col_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_idle;
      r_row    <= '0;
      r_settle <= '0;
      r_col    <= '0;
      r_flip   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (scan_en) begin
            r_state  <= c_drive;
            r_settle <= '0;
          end
        end
        c_drive: begin
          if (r_settle == SW'(SETTLE - 1)) begin
            r_state <= c_sample;
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end
        c_sample: begin
          r_state <= c_emit;
          r_col   <= '0;
          r_flip  <= w_flip_set;
        end
        c_emit: begin
          if (r_col == CB'(COLS - 1)) begin
            r_flip   <= '0;
            r_col    <= '0;
            r_settle <= '0;
            r_row    <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
            r_state  <= scan_en ? c_drive : c_idle;
          end else begin
            r_col <= r_col + CB'(1);
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  always_comb begin
    row_n = '1;
    if (r_state == c_drive || r_state == c_sample) begin
      row_n[r_row] = 1'b0;
    end
  end

  // Only the keys on the driven row are updated during SAMPLE.
  always_comb begin
    w_key_next = r_key_state;
    w_flip_set = '0;
    for (int k = 0; k < NKEYS; k++) begin
      w_cnt_next[k] = r_cnt[k];
      if (r_state == c_sample && r_row == RW'(k / COLS)) begin
        if (!r_col_sync[k % COLS] == r_key_state[k]) begin
          w_cnt_next[k] = '0;
        end else if (r_cnt[k] == DW'(STABLE - 1)) begin
          w_cnt_next[k]          = '0;
          w_key_next[k]          = ~r_key_state[k];
          w_flip_set[k % COLS]   = 1'b1;
        end else begin
          w_cnt_next[k] = r_cnt[k] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_state <= '0;
      for (int k = 0; k < NKEYS; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      r_key_state <= w_key_next;
      for (int k = 0; k < NKEYS; k++) begin
        r_cnt[k] <= w_cnt_next[k];
      end
    end
  end

  assign key_state  = r_key_state;
  assign w_emit_key = KW'(r_row * COLS + r_col);

  // Event FIFO; pointers carry one extra wrap bit to tell full from empty.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push    = (r_state == c_emit) && r_flip[r_col];
  assign w_pop     = !w_empty && evt_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= {w_emit_key, r_key_state[w_emit_key]};
        r_wr_ptr                <= r_wr_ptr + (AW + 1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
      end
    end
  end

  assign evt_valid              = !w_empty;
  assign {evt_code, evt_press}  = r_mem[r_rd_ptr[AW-1:0]];
  assign evt_drop               = w_push && w_full && !w_pop;

endmodule
`default_nettype wire
